mem_arbiter: RTL
================

# mem_arbiter

Arbitrates line-sized (128-bit) memory accesses from the instruction cache and the data cache onto the single-port `ram_memory` model. Sits directly upstream of `ram_memory`: it drives `data_requested`, `data_to_write` and `write_to_mem`, and captures `data_returned`. It models a fixed memory latency and returns each line to its requester with a one-cycle valid pulse. Only one access is in flight at a time.

## Interface
- `ADDR_W`, 26: word-address width, matching the RAM address.
- `LINE_W`, 128: line width; one line is 4 × 32-bit words.
- `MEM_LATENCY`, 5: cycles an access occupies the RAM; legal range ≥ 1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ic_req`  in  1  icache read request.
- `ic_addr`  in  ADDR_W  icache word address.
- `ic_ready`  out  1  icache request accepted this cycle.
- `ic_valid`  out  1  one-cycle pulse: `ic_data` holds the line.
- `ic_data`  out  LINE_W  returned line.
- `dc_req`  in  1  dcache request.
- `dc_we`  in  1  1 = write line, 0 = read line.
- `dc_addr`  in  ADDR_W  dcache word address.
- `dc_wdata`  in  LINE_W  write line.
- `dc_ready`  out  1  dcache request accepted this cycle.
- `dc_valid`  out  1  one-cycle pulse: read data, or write acknowledge.
- `dc_data`  out  LINE_W  returned line; 0 on a write acknowledge.
- `mem_addr`  out  ADDR_W  drives RAM `data_requested`.
- `mem_wdata`  out  LINE_W  drives RAM `data_to_write`.
- `mem_we`  out  1  drives RAM `write_to_mem`.
- `mem_rdata`  in  LINE_W  from RAM `data_returned`.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - Arbitrate.
  - Raise `ready` combinationally for the winner only.
  - On `req && ready`, latch the request (owner, addr, we, wdata) and go to WAIT.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins.
  - `last_grant` resets to icache, so dcache wins the first tie.
- Requester rule:
  - `req` and its payload must hold until `ready`.
  - Dropping `req` before `ready` is legal; nothing is accepted.
- Address alignment:
  - `mem_addr = {addr[ADDR_W-1:2], 2'b00}`; low 2 bits are ignored.
  - The top line (addr ≥ 2^26−4) aligns down; there is no wrap past the top.
- WAIT:
  - Counter loads `MEM_LATENCY−1` on accept and decrements each cycle.
  - `mem_addr` and `mem_wdata` are held stable for the whole of WAIT.
  - On the final WAIT cycle (count = 0):
    - write: `mem_we` = 1 for exactly that cycle;
    - read: `mem_rdata` is captured into the response register.
  - Then go to RESP.
- RESP:
  - Owner's `valid` = 1 for one cycle with `data` from the response register.
  - Update `last_grant`, then return to IDLE.
- `ic_ready` and `dc_ready` are 0 outside IDLE.
- A `req` that arrives during WAIT/RESP waits until IDLE.
- Non-owner `valid` = 0 always; `data` outputs hold their last value.
- `mem_we` = 0 in IDLE and RESP. `mem_addr` and `mem_wdata` hold their last value in IDLE.

## Timing
- Accept edge at cycle T.
- WAIT occupies T+1 … T+MEM_LATENCY.
- `valid` is high at T+MEM_LATENCY+1.
- Earliest next accept is at T+MEM_LATENCY+2.
- Throughput: one line per MEM_LATENCY+2 cycles.
- Reset values: state IDLE, both `ready` 0, both `valid` 0, `ic_data` and `dc_data` 0, `mem_addr` 0, `mem_wdata` 0, `mem_we` 0, counter 0, `last_grant` = icache.
- Reset asserted mid-WAIT/RESP:
  - next cycle is IDLE with all outputs at reset values;
  - the outstanding access is dropped (no `valid`, no further `mem_we`).
- Reset during the `mem_we` cycle: reset takes priority, and `mem_we` is 0 from the following edge.

## Structure
- `mem_pkg` holds:
  - `ADDR_W`, `LINE_W`;
  - `line_t` (logic [LINE_W-1:0]);
  - `arb_state_t` enum {IDLE, WAIT, RESP};
  - `owner_t` enum {OWN_IC, OWN_DC}.
- One natural sub-module: `rr_arbiter2`, a two-way round-robin grant that takes `last_grant` as input. Everything else stays in `mem_arbiter`.

## Test plan
- Reset, then `ic_req` with `ic_addr`=0x0000006, MEM_LATENCY=5:
  - `ic_ready` at T;
  - `mem_addr`=0x0000004 during T+1..T+5;
  - `ic_valid` at T+6 with `ic_data`={7,6,5,4} (RAM preload).
- `dc_req` write, `dc_addr`=0x10, `dc_wdata`=0xAAAA…:
  - `mem_we` high only at T+5;
  - `dc_valid` at T+6 with `dc_data`=0.
  - A following dcache read of 0x10 returns 0xAAAA….
- `ic_req` and `dc_req` both high after reset, both held:
  - dcache is served first, then icache;
  - a second simultaneous pair is served dcache then icache again (alternation holds).
- Back-to-back icache requests held high:
  - accepts exactly 7 cycles apart;
  - `ic_ready` never high during WAIT/RESP.
- `reset` driven low at T+3 of a dcache write:
  - no `mem_we` pulse, no `dc_valid`;
  - all outputs at reset values from T+4;
  - memory at the target is unchanged.
- MEM_LATENCY=1:
  - accept at T, `mem_we`/capture at T+1, `valid` at T+2.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the cache-to-RAM line arbiter.
package mem_pkg;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned LINE_W = 128;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant between icache and dcache; a tie goes to the side not granted last.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic   ic_req,
    input  logic   dc_req,
    input  owner_t last_grant,
    output logic   grant_valid_c,
    output owner_t grant_c
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        grant_valid_c = ic_req || dc_req;
        grant_c       = OWN_IC;
        if (ic_req && dc_req) begin
            grant_c = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
        end else if (dc_req) begin
            grant_c = OWN_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache line accesses onto a single-port RAM with a fixed latency.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic              ic_valid,
    output logic [LINE_W-1:0] ic_data,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic              dc_valid,
    output logic [LINE_W-1:0] dc_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    arb_state_t        state;
    owner_t            owner;
    owner_t            last_grant;
    logic              owner_we;
    logic [CNT_W-1:0]  cnt;

    logic              grant_valid_c;
    owner_t            grant_c;
    logic              accept_c;
    logic              acc_we_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [ADDR_W-1:0] acc_line_addr_c;

    rr_arbiter2 u_rr_arbiter2 (
        .ic_req        (ic_req),
        .dc_req        (dc_req),
        .last_grant    (last_grant),
        .grant_valid_c (grant_valid_c),
        .grant_c       (grant_c)
    );

    // Ready only in IDLE, only for the arbitration winner, and never while reset is held.
    assign ic_ready = reset && (state == IDLE) && grant_valid_c && (grant_c == OWN_IC);
    assign dc_ready = reset && (state == IDLE) && grant_valid_c && (grant_c == OWN_DC);
    assign accept_c = ic_ready || dc_ready;

    // Payload of the winning request; the address is aligned down to its line.
    assign acc_addr_c      = (grant_c == OWN_IC) ? ic_addr : dc_addr;
    assign acc_line_addr_c = acc_addr_c & ~ADDR_W'(3);
    assign acc_we_c        = (grant_c == OWN_DC) && dc_we;

    // Access sequencer: accept in IDLE, count out the RAM latency in WAIT, pulse valid in RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_IC;
            last_grant <= OWN_IC;
            owner_we   <= 1'b0;
            cnt        <= '0;
            ic_valid   <= 1'b0;
            ic_data    <= '0;
            dc_valid   <= 1'b0;
            dc_data    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state    <= WAIT;
                        owner    <= grant_c;
                        owner_we <= acc_we_c;
                        mem_addr <= acc_line_addr_c;
                        if (grant_c == OWN_DC) begin
                            mem_wdata <= dc_wdata;
                        end
                        cnt    <= CNT_W'(MEM_LATENCY - 1);
                        mem_we <= acc_we_c && (MEM_LATENCY == 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state  <= RESP;
                        mem_we <= 1'b0;
                        if (owner == OWN_IC) begin
                            ic_valid <= 1'b1;
                            ic_data  <= mem_rdata;
                        end else begin
                            dc_valid <= 1'b1;
                            dc_data  <= owner_we ? '0 : mem_rdata;
                        end
                    end else begin
                        cnt    <= cnt - CNT_W'(1);
                        mem_we <= owner_we && (cnt == CNT_W'(1));
                    end
                end
                RESP: begin
                    ic_valid   <= 1'b0;
                    dc_valid   <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
